// File: rtl/pulse_gen_top_if.sv
// Request/status bundle for the pulse burst generator.
// The master side issues burst requests. The slave side is the generator itself.
interface pulse_gen_top_if #(
  parameter int CH_NUM    = 32,
  parameter int CNT_WIDTH = 22,
  parameter int NUM_WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic [CH_NUM-1:0]    ch_mask;
  logic [CNT_WIDTH-1:0] high_len;
  logic [CNT_WIDTH-1:0] low_len;
  logic [NUM_WIDTH-1:0] pulse_num;
  logic [CH_NUM-1:0]    pulse_out;
  logic                 busy;
  logic                 done;
  logic [NUM_WIDTH-1:0] pulse_cnt;

  modport master (
    output start, abort, ch_mask, high_len, low_len, pulse_num,
    input  pulse_out, busy, done, pulse_cnt
  );

  modport slave (
    input  start, abort, ch_mask, high_len, low_len, pulse_num,
    output pulse_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/pulse_gen_top.sv
// Programmable multi-channel pulse burst generator.
// A start request latches the burst parameters and emits pulse_num pulses
// of high_len cycles, separated by max(low_len,1) idle cycles, on the masked channels.
// All outputs come from registers.
module pulse_gen_top #(
  parameter int CH_NUM    = 32,
  parameter int CNT_WIDTH = 22,
  parameter int NUM_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  pulse_gen_top_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t               state_q;
  logic [CH_NUM-1:0]    mask_q;
  logic [CNT_WIDTH-1:0] high_q;
  logic [CNT_WIDTH-1:0] low_q;
  logic [NUM_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] dur_q;
  logic [CH_NUM-1:0]    pulse_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NUM_WIDTH-1:0] pcnt_q;

  logic [NUM_WIDTH-1:0] pcnt_d;
  logic [CNT_WIDTH-1:0] low_load_d;
  logic [CNT_WIDTH-1:0] high_load_d;
  logic                 degen_d;

  // Count after the current high phase completes. pcnt_q < num_q while in HIGH, so this cannot wrap.
  assign pcnt_d      = pcnt_q + NUM_WIDTH'(1);
  // A zero low time is stretched to one cycle so back-to-back pulses stay distinct.
  assign low_load_d  = (low_q == '0) ? '0 : low_q - CNT_WIDTH'(1);
  assign high_load_d = high_q - CNT_WIDTH'(1);
  // A request that cannot produce a pulse goes straight to the completion strobe.
  assign degen_d     = (bus.pulse_num == '0) || (bus.high_len == '0) || (bus.ch_mask == '0);

  // Burst FSM. Every output is a register, updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      dur_q   <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            mask_q <= bus.ch_mask;
            high_q <= bus.high_len;
            low_q  <= bus.low_len;
            num_q  <= bus.pulse_num;
            pcnt_q <= '0;
            busy_q <= 1'b1;
            if (degen_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= HIGH;
              pulse_q <= bus.ch_mask;
              dur_q   <= bus.high_len - CNT_WIDTH'(1);
            end
          end
        end
        HIGH: begin
          if (bus.abort) begin
            // A partial pulse is dropped and not counted.
            state_q <= DONE;
            pulse_q <= '0;
            done_q  <= 1'b1;
          end else if (dur_q == '0) begin
            pcnt_q  <= pcnt_d;
            pulse_q <= '0;
            if (pcnt_d == num_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOW;
              dur_q   <= low_load_d;
            end
          end else begin
            dur_q <= dur_q - CNT_WIDTH'(1);
          end
        end
        LOW: begin
          if (bus.abort) begin
            state_q <= DONE;
            pulse_q <= '0;
            done_q  <= 1'b1;
          end else if (dur_q == '0) begin
            state_q <= HIGH;
            pulse_q <= mask_q;
            dur_q   <= high_load_d;
          end else begin
            dur_q <= dur_q - CNT_WIDTH'(1);
          end
        end
        DONE: begin
          // One-cycle strobe. Abort and start are both ignored here.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pcnt_q;

endmodule

// File: doc/pulse_gen_top.md
# pulse_gen_top

Programmable 32-channel pulse burst generator: the transmit-side counterpart of the 32-channel pulse filter. On a start request it drives a burst of identical pulses on a selected set of channels, with programmable high time, low time and pulse count. It sits in the test/stimulus path, ahead of the filter, so that filter thresholds can be exercised with pulses just above and just below the filter coefficient.

## Interface
- CH_NUM, 32: number of output channels.
- CNT_WIDTH, 22: width of the high/low duration fields; matches the filter counter width.
- NUM_WIDTH, 8: width of the pulse-count field.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- abort  in  1  terminates a running burst.
- ch_mask  in  CH_NUM  channels that carry the burst.
- high_len  in  CNT_WIDTH  pulse high time, in clk cycles.
- low_len  in  CNT_WIDTH  gap between pulses, in clk cycles.
- pulse_num  in  NUM_WIDTH  number of pulses in the burst.
- pulse_out  out  CH_NUM  registered pulse outputs.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion strobe.
- pulse_cnt  out  NUM_WIDTH  completed high phases in the current or last burst.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE, start=1, abort=0:
  - Latch ch_mask, high_len, low_len and pulse_num into internal registers.
  - Clear pulse_cnt.
  - Load the duration counter.
  - Go to HIGH.
- Degenerate request: if pulse_num==0, high_len==0 or ch_mask==0, go IDLE→DONE directly. No pulse is emitted and pulse_cnt stays 0.
- HIGH:
  - pulse_out = latched mask for exactly high_len cycles.
  - On the last cycle, pulse_cnt increments.
  - If pulse_cnt+1 == pulse_num, go to DONE; else go to LOW.
- LOW:
  - pulse_out = 0 for max(low_len,1) cycles. low_len==0 is treated as 1 so that pulses stay distinct.
  - Then return to HIGH.
- DONE: done=1 for one cycle, then go to IDLE.
- Inputs are not re-sampled during a burst. Changes to ch_mask or the length inputs while busy have no effect.
- start while busy is ignored. It is not queued.
- abort in HIGH or LOW: next state is DONE, and pulse_out is 0 from the next cycle. pulse_cnt holds the high phases completed so far; a partial pulse is not counted.
- abort in IDLE is ignored. abort with start in the same cycle in IDLE: abort wins, the FSM stays in IDLE, and nothing is latched.
- abort in DONE has no effect.
- Counters:
  - Duration counter is CNT_WIDTH wide and counts down, loaded with len-1.
  - No wrap: the maximum length 2^CNT_WIDTH-1 is supported exactly.
  - pulse_cnt saturates at pulse_num by construction.
- rst in any state:
  - Next cycle the FSM is in IDLE.
  - pulse_out=0, busy=0, done=0, pulse_cnt=0, latched registers cleared.
  - A burst in progress is dropped with no done strobe.

## Timing
- Reset values: pulse_out=0, busy=0, done=0, pulse_cnt=0.
- All outputs are registered; there are no combinational input-to-output paths.
- start accepted at edge N:
  - pulse_out goes high at N+1.
  - busy=1 from N+1 through the done cycle inclusive.
- Burst duration, with h=high_len, l=max(low_len,1), n=pulse_num:
  - done asserts at cycle N+1+h·n+l·(n-1).
  - busy falls the cycle after done.
- Degenerate request: busy=1 and done=1 together at N+1, both low at N+2.
- abort sampled at edge M in HIGH/LOW: pulse_out=0 and done=1 at M+1, busy=0 at M+2.
- A new start is accepted at the earliest on the cycle after done, when the FSM is in IDLE.

## Test plan
- Basic burst: mask=0x0000_0005, high=3, low=2, num=2, start at cycle 0.
  - pulse_out=0x5 in cycles 1–3 and 6–8, and 0 in cycles 4–5.
  - done at cycle 9, busy cycles 1–9, pulse_cnt=2.
- Degenerate and minimum cases:
  - num=0: done at cycle 1, pulse_out always 0, pulse_cnt=0.
  - high=1, low=0, num=3, mask=0xFFFF_FFFF: alternating 1/0 pattern over cycles 1–5, done at cycle 6.
- Abort: high=10, num=1, abort at cycle 4.
  - pulse_out=0 and done=1 at cycle 5, pulse_cnt=0.
  - abort together with start in IDLE: busy stays 0.
- Ignored inputs:
  - start and input changes while busy: new start mid-burst and ch_mask changed to 0xFFFF_0000 → output pattern unchanged, exactly one done.
- Reset mid-burst: rst asserted in LOW.
  - Next cycle all outputs are 0 and no done strobe occurs.
  - A fresh start afterwards behaves as the basic burst.
- Loopback: generator feeding the pulse filter with coefficient K.
  - high=K-1: filter output stays 0.
  - high=K+2: filter output toggles once per pulse.
